// File: rtl/phy_rx_multilane.sv
// Multi-lane serial receiver: per-lane COM alignment and lock, per-lane hold
// registers that absorb sub-byte skew, and unstriping of lane bytes into words.
module phy_rx_multilane #(
  parameter int         LANES       = 2,
  parameter int         WORD_W      = 32,
  parameter logic [7:0] COM         = 8'hBC,
  parameter int         ALIGN_COUNT = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic [LANES-1:0]  data_in,
  output logic [WORD_W-1:0] data_out,
  output logic              valid_out,
  output logic [LANES-1:0]  lane_locked,
  output logic              err_out
);

  localparam int GROUPS = WORD_W / 8 / LANES;
  localparam int PTR_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int CNT_W  = $clog2(ALIGN_COUNT + 1);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_ALIGN  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [7:0]        sr_q      [LANES];
  logic [7:0]        sr_d      [LANES];
  logic [1:0]        st_q      [LANES];
  logic [1:0]        st_d      [LANES];
  logic [2:0]        bit_cnt_q [LANES];
  logic [2:0]        bit_cnt_d [LANES];
  logic [CNT_W-1:0]  com_cnt_q [LANES];
  logic [CNT_W-1:0]  com_cnt_d [LANES];
  logic [7:0]        hold_q    [LANES];
  logic [7:0]        hold_d    [LANES];
  logic [LANES-1:0]  hold_full_q, hold_full_d;
  logic [LANES-1:0]  hold_com_q, hold_com_d;
  logic [LANES-1:0]  lane_locked_q, lane_locked_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [WORD_W-1:0] data_out_q, data_out_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic [7:0]        sr_next [LANES];
  logic [LANES-1:0]  byte_done;
  logic              all_full, all_com, any_com, group_err, overrun;
  logic [WORD_W-1:0] word_tmp;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sr_next[i]   = {sr_q[i][6:0], data_in[i]};
      byte_done[i] = (st_q[i] != ST_SEARCH) && (bit_cnt_q[i] == 3'd7);
    end
  end

  assign all_full  = &hold_full_q;
  assign all_com   = &hold_com_q;
  assign any_com   = |hold_com_q;
  assign group_err = all_full && any_com && !all_com;
  // A locked lane finishing a byte while still holding the previous one has
  // outrun its peers by more than a byte; alignment is no longer trustworthy.
  assign overrun   = !all_full && |(byte_done & hold_full_q);

  always_comb begin
    sr_d          = sr_q;
    st_d          = st_q;
    bit_cnt_d     = bit_cnt_q;
    com_cnt_d     = com_cnt_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    hold_com_d    = hold_com_q;
    lane_locked_d = lane_locked_q;
    ptr_d         = ptr_q;
    asm_d         = asm_q;
    data_out_d    = data_out_q;
    valid_d       = 1'b0;
    err_d         = 1'b0;
    word_tmp      = asm_q;

    if (all_full) begin
      hold_full_d = '0;
      if (all_com) begin
        if (ptr_q != '0) err_d = 1'b1;
        ptr_d = '0;
      end else if (!any_com) begin
        for (int i = 0; i < LANES; i++) begin
          word_tmp[WORD_W-1-8*(int'(ptr_q)*LANES+i) -: 8] = hold_q[i];
        end
        asm_d = word_tmp;
        if (ptr_q == PTR_W'(GROUPS-1)) begin
          data_out_d = word_tmp;
          valid_d    = 1'b1;
          ptr_d      = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
    end

    for (int i = 0; i < LANES; i++) begin
      sr_d[i]      = sr_next[i];
      bit_cnt_d[i] = bit_cnt_q[i] + 3'd1;
      case (st_q[i])
        ST_SEARCH: begin
          if (sr_next[i] == COM) begin
            bit_cnt_d[i] = 3'd0;
            com_cnt_d[i] = CNT_W'(1);
            if (ALIGN_COUNT <= 1) begin
              st_d[i]          = ST_LOCKED;
              lane_locked_d[i] = 1'b1;
            end else begin
              st_d[i] = ST_ALIGN;
            end
          end
        end
        ST_ALIGN: begin
          if (byte_done[i]) begin
            if (sr_next[i] == COM) begin
              com_cnt_d[i] = CNT_W'(com_cnt_q[i] + 1'b1);
              if (CNT_W'(com_cnt_q[i] + 1'b1) == CNT_W'(ALIGN_COUNT)) begin
                st_d[i]          = ST_LOCKED;
                lane_locked_d[i] = 1'b1;
              end
            end else begin
              st_d[i]      = ST_SEARCH;
              com_cnt_d[i] = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (byte_done[i]) begin
            hold_d[i]      = sr_next[i];
            hold_com_d[i]  = (sr_next[i] == COM);
            hold_full_d[i] = 1'b1;
          end
        end
        default: st_d[i] = ST_SEARCH;
      endcase
    end

    if (group_err || overrun) begin
      err_d         = 1'b1;
      ptr_d         = '0;
      hold_full_d   = '0;
      lane_locked_d = '0;
      for (int i = 0; i < LANES; i++) begin
        st_d[i]      = ST_SEARCH;
        com_cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        sr_q[i]      <= '0;
        st_q[i]      <= ST_SEARCH;
        bit_cnt_q[i] <= '0;
        com_cnt_q[i] <= '0;
        hold_q[i]    <= '0;
      end
      hold_full_q   <= '0;
      hold_com_q    <= '0;
      lane_locked_q <= '0;
      ptr_q         <= '0;
      asm_q         <= '0;
      data_out_q    <= '0;
      valid_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      sr_q          <= sr_d;
      st_q          <= st_d;
      bit_cnt_q     <= bit_cnt_d;
      com_cnt_q     <= com_cnt_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      hold_com_q    <= hold_com_d;
      lane_locked_q <= lane_locked_d;
      ptr_q         <= ptr_d;
      asm_q         <= asm_d;
      data_out_q    <= data_out_d;
      valid_q       <= valid_d;
      err_q         <= err_d;
    end
  end

  assign data_out    = data_out_q;
  assign valid_out   = valid_q;
  assign lane_locked = lane_locked_q;
  assign err_out     = err_q;

endmodule

// File: tb/tb_phy_rx_multilane.sv
// Bench for phy_rx_multilane: a 2-lane/32-bit and a 4-lane/64-bit instance fed
// from shared per-lane byte streams, checked against a byte-group reference model.
module tb_phy_rx_multilane;

  localparam logic [7:0] COMB = 8'hBC;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] lanes = '0;

  always #5 clk = ~clk;

  logic [31:0] do2;
  logic        v2, e2;
  logic [1:0]  lk2;
  logic [63:0] do4;
  logic        v4, e4;
  logic [3:0]  lk4;

  phy_rx_multilane #(.LANES(2), .WORD_W(32)) u_d2 (
    .clk_32f(clk), .reset(reset), .data_in(lanes[1:0]),
    .data_out(do2), .valid_out(v2), .lane_locked(lk2), .err_out(e2));

  phy_rx_multilane #(.LANES(4), .WORD_W(64)) u_d4 (
    .clk_32f(clk), .reset(reset), .data_in(lanes[3:0]),
    .data_out(do4), .valid_out(v4), .lane_locked(lk4), .err_out(e4));

  int nchk = 0;
  int npass = 0;
  int cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  logic [63:0] w2_q[$];
  logic [63:0] w4_q[$];
  int nv2, nv4, ne2, ne4, vcyc2, lock2;
  logic [1:0] lkor2;

  always @(negedge clk) begin
    if (v2) begin w2_q.push_back({32'h0, do2}); nv2++; vcyc2 = cyc; end
    if (v4) begin w4_q.push_back(do4); nv4++; end
    if (e2) ne2++;
    if (e4) ne4++;
    if (lk2 == 2'b11 && lock2 < 0) lock2 = cyc;
    lkor2 = lkor2 | lk2;
  end

  logic [7:0] sb [8][256];
  int         llen [8];
  int         skew [8];
  bit         trail_com;
  int         ntrail;
  int         start_edge;

  task automatic clear_mon();
    w2_q.delete(); w4_q.delete();
    nv2 = 0; nv4 = 0; ne2 = 0; ne4 = 0; vcyc2 = -1; lock2 = -1; lkor2 = '0;
  endtask

  task automatic clr_stream();
    for (int l = 0; l < 8; l++) begin llen[l] = 0; skew[l] = 0; end
    trail_com = 1'b1;
    ntrail = 2;
  endtask

  task automatic put(input int l, input logic [7:0] v);
    sb[l][llen[l]] = v;
    llen[l]++;
  endtask

  task automatic put_all(input int n, input logic [7:0] v);
    for (int k = 0; k < n; k++)
      for (int l = 0; l < 8; l++) put(l, v);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1; lanes = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_mon();
    clr_stream();
  endtask

  // Serialise every lane MSB first; lane l is delayed by skew[l] bit-times.
  task automatic send_stream();
    int mx;
    int nb;
    mx = 0;
    for (int l = 0; l < 8; l++) if (llen[l] > mx) mx = llen[l];
    nb = (mx + ntrail) * 8 + 8;
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      if (b == 0) start_edge = cyc + 1;
      for (int l = 0; l < 8; l++) begin
        int idx;
        logic [7:0] cur;
        idx = b - skew[l];
        if (idx < 0) cur = 8'h00;
        else if (idx / 8 < llen[l]) cur = sb[l][idx/8];
        else cur = trail_com ? COMB : 8'h00;
        lanes[l] = (idx < 0) ? 1'b0 : cur[7-(idx%8)];
      end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    nchk++; if (do2 !== 32'h0) $display("FAIL reset_data2 got=%h exp=%h", do2, 32'h0); else npass++;
    nchk++; if (v2 !== 1'b0) $display("FAIL reset_valid2 got=%b exp=0", v2); else npass++;
    nchk++; if (lk2 !== 2'b00) $display("FAIL reset_lock2 got=%b exp=00", lk2); else npass++;
    nchk++; if (e2 !== 1'b0) $display("FAIL reset_err2 got=%b exp=0", e2); else npass++;
    nchk++; if (do4 !== 64'h0) $display("FAIL reset_data4 got=%h exp=%h", do4, 64'h0); else npass++;
    nchk++; if (lk4 !== 4'b0000) $display("FAIL reset_lock4 got=%b exp=0000", lk4); else npass++;
    do_reset();
    repeat (3) @(negedge clk);
    nchk++; if (nv2 + ne2 + nv4 + ne4 !== 0) $display("FAIL reset_quiet got=%0d pulses exp=0", nv2 + ne2 + nv4 + ne4); else npass++;
  endtask

  task automatic build_basic();
    put_all(4, COMB);
    put(0, 8'h11); put(0, 8'h33);
    put(1, 8'h22); put(1, 8'h44);
  endtask

  task automatic test_basic();
    do_reset();
    build_basic();
    send_stream();
    nchk++; if (lock2 !== start_edge + 31) $display("FAIL basic_lock_time got=%0d exp=%0d", lock2, start_edge + 31); else npass++;
    nchk++; if (lk2 !== 2'b11) $display("FAIL basic_locked got=%b exp=11", lk2); else npass++;
    nchk++; if (nv2 !== 1) $display("FAIL basic_valid_count got=%0d exp=1", nv2); else npass++;
    nchk++; if (do2 !== 32'h11223344) $display("FAIL basic_word got=%h exp=11223344", do2); else npass++;
    nchk++; if (vcyc2 !== start_edge + 48) $display("FAIL basic_latency got=%0d exp=%0d", vcyc2, start_edge + 48); else npass++;
    nchk++; if (ne2 !== 0) $display("FAIL basic_err got=%0d exp=0", ne2); else npass++;
  endtask

  task automatic test_skew();
    do_reset();
    build_basic();
    skew[1] = 5;
    send_stream();
    nchk++; if (nv2 !== 1) $display("FAIL skew_valid_count got=%0d exp=1", nv2); else npass++;
    nchk++; if (do2 !== 32'h11223344) $display("FAIL skew_word got=%h exp=11223344", do2); else npass++;
    nchk++; if (ne2 !== 0) $display("FAIL skew_err got=%0d exp=0", ne2); else npass++;
  endtask

  task automatic test_idle_midword();
    do_reset();
    put_all(4, COMB);
    put(0, 8'h11); put(1, 8'h22);
    put(0, COMB);  put(1, COMB);
    put(0, 8'h55); put(1, 8'h66);
    put(0, 8'h77); put(1, 8'h88);
    send_stream();
    nchk++; if (ne2 !== 1) $display("FAIL idle_mid_err got=%0d exp=1", ne2); else npass++;
    nchk++; if (nv2 !== 1) $display("FAIL idle_mid_valid_count got=%0d exp=1", nv2); else npass++;
    nchk++; if (do2 !== 32'h55667788) $display("FAIL idle_mid_word got=%h exp=55667788", do2); else npass++;
    nchk++; if (lk2 !== 2'b11) $display("FAIL idle_mid_locked got=%b exp=11", lk2); else npass++;
  endtask

  task automatic test_mixed();
    do_reset();
    put_all(4, COMB);
    put(0, COMB); put(1, 8'h55);
    put_all(3, COMB);
    put(0, 8'h11); put(1, 8'h22);
    put(0, 8'h33); put(1, 8'h44);
    trail_com = 1'b0; ntrail = 1;
    send_stream();
    nchk++; if (ne2 !== 1) $display("FAIL mixed_err got=%0d exp=1", ne2); else npass++;
    nchk++; if (lk2 !== 2'b00) $display("FAIL mixed_unlocked got=%b exp=00", lk2); else npass++;
    nchk++; if (nv2 !== 0) $display("FAIL mixed_no_valid got=%0d exp=0", nv2); else npass++;
    clear_mon();
    clr_stream();
    build_basic();
    send_stream();
    nchk++; if (lk2 !== 2'b11) $display("FAIL mixed_relock got=%b exp=11", lk2); else npass++;
    nchk++; if (do2 !== 32'h11223344 || nv2 !== 1) $display("FAIL mixed_relock_word got=%h/%0d exp=11223344/1", do2, nv2); else npass++;
  endtask

  task automatic test_misalign();
    do_reset();
    put_all(3, COMB);
    put(0, 8'h00);
    for (int k = 0; k < 4; k++) put(1, 8'h00);
    for (int l = 2; l < 8; l++) llen[l] = 0;
    trail_com = 1'b0; ntrail = 1;
    send_stream();
    nchk++; if (lkor2 !== 2'b00) $display("FAIL short_com_lock got=%b exp=00", lkor2); else npass++;
    nchk++; if (ne2 !== 0) $display("FAIL short_com_err got=%0d exp=0", ne2); else npass++;
    clear_mon();
    clr_stream();
    build_basic();
    skew[0] = 3;
    send_stream();
    nchk++; if (lk2 !== 2'b11) $display("FAIL misalign_lock got=%b exp=11", lk2); else npass++;
    nchk++; if (do2 !== 32'h11223344 || nv2 !== 1) $display("FAIL misalign_word got=%h/%0d exp=11223344/1", do2, nv2); else npass++;
  endtask

  task automatic test_overrun();
    do_reset();
    put_all(4, COMB);
    put(0, 8'h00); put(0, 8'h00);
    for (int l = 1; l < 8; l++) llen[l] = 0;
    trail_com = 1'b0; ntrail = 1;
    send_stream();
    nchk++; if (lkor2 !== 2'b01) $display("FAIL overrun_lane0_locked got=%b exp=01", lkor2); else npass++;
    nchk++; if (ne2 !== 1) $display("FAIL overrun_err got=%0d exp=1", ne2); else npass++;
    nchk++; if (lk2 !== 2'b00 || nv2 !== 0) $display("FAIL overrun_state got=%b/%0d exp=00/0", lk2, nv2); else npass++;
  endtask

  task automatic build_lanes4();
    put_all(4, COMB);
    for (int l = 0; l < 4; l++) put(l, 8'(l + 1));
    for (int l = 0; l < 4; l++) put(l, 8'(l + 5));
  endtask

  task automatic test_lanes4();
    do_reset();
    build_lanes4();
    send_stream();
    nchk++; if (lk4 !== 4'b1111) $display("FAIL l4_locked got=%b exp=1111", lk4); else npass++;
    nchk++; if (do4 !== 64'h0102030405060708 || nv4 !== 1) $display("FAIL l4_word got=%h/%0d exp=0102030405060708/1", do4, nv4); else npass++;
  endtask

  task automatic test_reset_midword();
    do_reset();
    build_lanes4();
    trail_com = 1'b0; ntrail = 1;
    fork
      send_stream();
      begin
        repeat (8*5 + 4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        nchk++; if (do4 !== 64'h0 || v4 !== 1'b0 || lk4 !== 4'b0 || e4 !== 1'b0)
          $display("FAIL midreset_outputs got=%h/%b/%b/%b exp=0/0/0/0", do4, v4, lk4, e4); else npass++;
        @(posedge clk); #1 reset = 1'b0;
      end
    join
    nchk++; if (nv4 !== 0 || ne4 !== 0) $display("FAIL midreset_no_valid got=%0d/%0d exp=0/0", nv4, ne4); else npass++;
    nchk++; if (do4 !== 64'h0 || lk4 !== 4'b0) $display("FAIL midreset_after got=%h/%b exp=0/0", do4, lk4); else npass++;
  endtask

  // Reference: after the lock preamble each byte index forms one lane group;
  // groups are classified idle/data and data bytes are packed into words.
  task automatic test_random(input int cfg, input int iters);
    int L, G, W, ptr, nerr, nitems, kind, k;
    logic [63:0] acc;
    logic [63:0] exp_w[$];
    logic [63:0] got[$];
    logic [7:0]  b, lkv, lkexp;
    L = (cfg != 0) ? 4 : 2;
    W = (cfg != 0) ? 64 : 32;
    G = W / 8 / L;
    for (int it = 0; it < iters; it++) begin
      do_reset();
      for (int l = 0; l < 8; l++) skew[l] = $urandom_range(0, 7);
      put_all(4, COMB);
      nitems = $urandom_range(4, 8);
      for (int n = 0; n < nitems; n++) begin
        kind = $urandom_range(0, 3);
        k = (kind == 0) ? 0 : (kind == 3) ? $urandom_range(1, G - 1) : G;
        for (int g = 0; g < k; g++)
          for (int l = 0; l < 8; l++) begin
            do b = 8'($urandom_range(0, 255)); while (b == COMB);
            put(l, b);
          end
        if (kind == 0 || kind == 3) put_all(1, COMB);
      end
      exp_w.delete();
      ptr = 0; nerr = 0; acc = '0;
      for (int g = 4; g < llen[0]; g++) begin
        int ncom;
        ncom = 0;
        for (int l = 0; l < L; l++) if (sb[l][g] == COMB) ncom++;
        if (ncom == L) begin
          if (ptr != 0) nerr++;
          ptr = 0; acc = '0;
        end else begin
          for (int l = 0; l < L; l++) acc[W-1-8*(ptr*L+l) -: 8] = sb[l][g];
          ptr++;
          if (ptr == G) begin exp_w.push_back(acc); ptr = 0; acc = '0; end
        end
      end
      send_stream();
      if (cfg != 0) begin got = w4_q; lkv = {4'b0, lk4}; end
      else begin got = w2_q; lkv = {6'b0, lk2}; end
      lkexp = 8'((1 << L) - 1);
      nchk++; if (got.size() !== exp_w.size()) $display("FAIL rand%0d_word_count got=%0d exp=%0d", L, got.size(), exp_w.size()); else npass++;
      for (int i = 0; i < exp_w.size(); i++) begin
        if (i < got.size()) begin
          nchk++; if (got[i] !== exp_w[i]) $display("FAIL rand%0d_word%0d got=%h exp=%h", L, i, got[i], exp_w[i]); else npass++;
        end
      end
      nchk++; if (((cfg != 0) ? ne4 : ne2) !== nerr) $display("FAIL rand%0d_err got=%0d exp=%0d", L, (cfg != 0) ? ne4 : ne2, nerr); else npass++;
      nchk++; if (lkv !== lkexp) $display("FAIL rand%0d_locked got=%b exp=%b", L, lkv, lkexp); else npass++;
    end
  endtask

  initial begin
    clear_mon();
    clr_stream();
    test_reset();
    test_basic();
    test_skew();
    test_idle_midword();
    test_mixed();
    test_misalign();
    test_overrun();
    test_lanes4();
    test_reset_midword();
    test_random(0, 4);
    test_random(1, 4);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
